// File: rtl/simp_comm_pkg.sv
// Shared definitions for the simple 4-bit serial link (receiver and future transmitter).
// Optional feature macro: SIMP_COMM_PARITY_EN adds the PARITY state (even parity).
package simp_comm_pkg;

  localparam int   MSG_W     = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SIMP_COMM_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 (idle line level).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here make the two stages shift, not collapse into one flop.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/simp_comm_rx.sv
// Serial receiver: start bit, 4 data bits LSB first, optional even parity, stop bit.
// Optional feature macro: SIMP_COMM_PARITY_EN (adds the PARITY state and parity check).
// All timing is measured on the synchronized line sin_s.
module simp_comm_rx
  import simp_comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  output logic [MSG_W-1:0] received_message,
  output logic             msg_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(MSG_W);

  // Mid-bit sample points: half a bit after the start edge, then every full bit.
  localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(MSG_W - 1);

  logic             sin_s;
  logic             sin_prev_q, sin_prev_d;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [MSG_W-1:0] shift_q, shift_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             msg_valid_q, msg_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_ok;
`ifdef SIMP_COMM_PARITY_EN
  logic             parity_q, parity_d;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (serial_in),
    .q     (sin_s)
  );

`ifdef SIMP_COMM_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok = ~(^{shift_q, parity_q});
`else
  assign parity_ok = 1'b1;
`endif

  // Next-state and datapath logic for the frame decoder.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    msg_d       = msg_q;
    msg_valid_d = 1'b0;
    frame_err_d = 1'b0;
    sin_prev_d  = sin_s;
`ifdef SIMP_COMM_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Only a real high-to-low edge starts a frame; a line stuck low does not.
        if (sin_prev_q == STOP_BIT && sin_s == START_BIT) begin
          state_d = ST_START;
          timer_d = '0;
        end
      end

      ST_START: begin
        if (timer_q == T_HALF) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = (sin_s == START_BIT) ? ST_DATA : ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_DATA: begin
        if (timer_q == T_FULL) begin
          timer_d   = '0;
          shift_d   = {sin_s, shift_q[MSG_W-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SIMP_COMM_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

`ifdef SIMP_COMM_PARITY_EN
      ST_PARITY: begin
        if (timer_q == T_FULL) begin
          timer_d  = '0;
          parity_d = sin_s;
          state_d  = ST_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif

      ST_STOP: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          state_d = ST_IDLE;
          if (sin_s == STOP_BIT && parity_ok) begin
            msg_d       = shift_q;
            msg_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset restores the idle line view and clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SIMP_COMM_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      sin_prev_q  <= sin_prev_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      frame_err_q <= frame_err_d;
`ifdef SIMP_COMM_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign received_message = msg_q;
  assign msg_valid        = msg_valid_q;
  assign frame_err        = frame_err_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_simp_comm_rx.sv
// Self-checking bench for simp_comm_rx (CLKS_PER_BIT = 4). Frames are driven bit by bit;
// a scoreboard queue holds the outcome each frame must produce, derived from the frame
// contents alone (stop level and even parity), and a monitor matches every output pulse.
module tb_simp_comm_rx;

  localparam int CPB = 4;
`ifdef SIMP_COMM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic [3:0] received_message;
  logic       msg_valid;
  logic       frame_err;
  logic       busy;

  simp_comm_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .serial_in        (serial_in),
    .received_message (received_message),
    .msg_valid        (msg_valid),
    .frame_err        (frame_err),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       good;
    logic [3:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] ref_msg;
  int         total;
  int         bad;
  int         mv_cnt;
  int         fe_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding frame outcome.
  always @(negedge clk) begin
    if (rst_n && (msg_valid || frame_err)) begin
      exp_t e;
      if (msg_valid) mv_cnt++;
      if (frame_err) fe_cnt++;
      check("pulse_exclusive", 32'(msg_valid && frame_err), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(msg_valid), 32'(e.good));
        if (e.good) ref_msg = e.data;
        check("pulse_msg", 32'(received_message), 32'(ref_msg));
      end
    end
  end

  // Hold the line at one level for a whole bit period (called at a falling clock edge).
  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    serial_in = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // Send one complete frame and record what it must produce.
  task automatic send_frame(input logic [3:0] d, input logic par, input logic stop);
    exp_t e;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
    e.good = stop && (!PAR_EN || (par == ^d));
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m0;
    int f0;
    total     = 0;
    bad       = 0;
    mv_cnt    = 0;
    fe_cnt    = 0;
    ref_msg   = 4'h0;
    rst_n     = 1'b0;
    serial_in = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_msg", 32'(received_message), 0);
    check("rst_mv", 32'(msg_valid), 0);
    check("rst_fe", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle_bits(1);

    // Good frame 4'hA: pulse exactly one cycle after the stop bit ends
    send_frame(4'hA, ^4'hA, 1'b1);
    check("a_pre_mv", 32'(msg_valid), 0);
    @(negedge clk);
    check("a_mv", 32'(msg_valid), 1);
    check("a_msg", 32'(received_message), 32'hA);
    @(negedge clk);
    check("a_mv_low", 32'(msg_valid), 0);
    check("a_busy", 32'(busy), 0);
    idle_bits(2);

    // One-clock glitch: nothing happens
    m0 = mv_cnt;
    f0 = fe_cnt;
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_mv", 32'(mv_cnt), 32'(m0));
    check("glitch_fe", 32'(fe_cnt), 32'(f0));
    check("glitch_msg", 32'(received_message), 32'hA);
    check("glitch_busy", 32'(busy), 0);

    // Good 4'h3, then 4'h5 with a bad stop and the line left low
    send_frame(4'h3, ^4'h3, 1'b1);
    idle_bits(1);
    check("g3_msg", 32'(received_message), 32'h3);
    f0 = fe_cnt;
    send_frame(4'h5, ^4'h5, 1'b0);
    repeat (12) @(negedge clk);
    check("stop_err_cnt", 32'(fe_cnt - f0), 1);
    check("stop_err_msg", 32'(received_message), 32'h3);
    check("stop_err_busy", 32'(busy), 0);
    idle_bits(2);
    check("stop_err_once", 32'(fe_cnt - f0), 1);

`ifdef SIMP_COMM_PARITY_EN
    // Parity: 4'h7 has odd weight, so the even-parity bit must be 1
    f0 = fe_cnt;
    m0 = mv_cnt;
    send_frame(4'h7, 1'b0, 1'b1);
    idle_bits(1);
    check("par_bad_fe", 32'(fe_cnt - f0), 1);
    check("par_bad_msg", 32'(received_message), 32'h3);
    send_frame(4'h7, 1'b1, 1'b1);
    idle_bits(1);
    check("par_good_mv", 32'(mv_cnt - m0), 1);
    check("par_good_msg", 32'(received_message), 32'h7);
`endif

    // Reset during data bit 2 discards the frame; the next frame is clean
    m0 = mv_cnt;
    f0 = fe_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_msg", 32'(received_message), 0);
    check("midrst_mv", 32'(msg_valid), 0);
    check("midrst_fe", 32'(frame_err), 0);
    check("midrst_busy", 32'(busy), 0);
    ref_msg = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    check("midrst_no_mv", 32'(mv_cnt), 32'(m0));
    check("midrst_no_fe", 32'(fe_cnt), 32'(f0));
    send_frame(4'hC, ^4'hC, 1'b1);
    idle_bits(1);
    check("after_rst_mv", 32'(mv_cnt - m0), 1);
    check("after_rst_msg", 32'(received_message), 32'hC);

    // Back-to-back frames with no idle gap
    m0 = mv_cnt;
    send_frame(4'h1, ^4'h1, 1'b1);
    send_frame(4'hF, ^4'hF, 1'b1);
    idle_bits(2);
    check("b2b_cnt", 32'(mv_cnt - m0), 2);
    check("b2b_msg", 32'(received_message), 32'hF);

    // Randomized frames: random data, occasional bad stop / bad parity, random gaps
    for (int n = 0; n < 40; n++) begin
      logic [3:0] d;
      logic       stop;
      logic       par;
      int         gap;
      d    = 4'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      par  = (^d) ^ ($urandom_range(0, 5) == 0);
      gap  = $urandom_range(0, 3);
      if (!stop && gap == 0) gap = 1;
      send_frame(d, par, stop);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(3);
    check("drain", 32'(exp_q.size()), 0);
    check("final_msg", 32'(received_message), 32'(ref_msg));
    check("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simp_comm_rx.md
SIMP_COMM_RX -- requirements
Module: simp_comm_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4: clocks per serial bit; legal values are even and >= 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port serial_in, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port received_message, output, 4 bits: last good decoded message.
REQ-006 The block SHALL have port msg_valid, output, 1 bit: one-cycle pulse when received_message updates.
REQ-007 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a rejected frame.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 The block SHALL decode frames of: start bit (0), 4 data bits LSB first, optional even-parity bit (see Configuration), stop bit (1).
REQ-010 serial_in SHALL pass through a 2-flop synchronizer before any use; all later timing is relative to the synchronized line (sin_s).
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: a 1-to-0 transition on sin_s SHALL move the FSM to START and load the bit timer; a line held low never triggers a start.
REQ-013 START: at CLKS_PER_BIT/2 cycles after entry, the FSM SHALL sample sin_s; if 0, go to DATA; if 1, treat it as a glitch, return to IDLE, and pulse nothing.
REQ-014 DATA: the FSM SHALL sample data bit i at CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT cycles after START entry, shift it into a 4-bit register, and after bit 3 go to PARITY if enabled, else STOP.
REQ-015 STOP: the FSM SHALL sample one CLKS_PER_BIT after the last data or parity sample.
  - If stop = 1 and parity is OK: load received_message and pulse msg_valid in the next cycle.
  - Otherwise: pulse frame_err in the next cycle and leave received_message unchanged.
REQ-016 After STOP, the FSM SHALL return to IDLE, and a new start edge SHALL be accepted from the cycle after the return (back-to-back frames are supported).
REQ-017 msg_valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-018 After a stop-bit error with the line held low, the FSM SHALL stay in IDLE until sin_s returns high and falls again.
REQ-019 The bit timer width SHALL be $clog2(CLKS_PER_BIT), and the timer SHALL wrap to 0 on each sample.

Reset
REQ-020 On rst_n low, the block SHALL asynchronously force: state IDLE; received_message 4'h0; msg_valid, frame_err and busy 0; shift register and timers 0; synchronizer flops 1.
REQ-021 A reset mid-frame SHALL discard the partial frame without pulsing any output, and the first falling edge after reset release SHALL start a new frame.

Configuration
REQ-022 With macro SIMP_COMM_PARITY_EN defined, the PARITY state SHALL exist: one even-parity bit follows data bit 3, and a frame is good only if the XOR of the 4 data bits and the parity bit is 0.
REQ-023 Without SIMP_COMM_PARITY_EN, the PARITY state and its logic SHALL be absent, and the frame length SHALL be 6 bits.

Structure
REQ-024 Package simp_comm_pkg SHALL hold the state enum typedef, MSG_W = 4, START_BIT = 0 and STOP_BIT = 1, shared with the future transmitter.
REQ-025 The synchronizer SHALL be a sub-module sync_2ff (reset value 1); all other logic SHALL be in simp_comm_rx.

Verification (CLKS_PER_BIT = 4)
REQ-026 Frame for 4'hA (bits 0,1,0,1 LSB first) with a good stop -> received_message = 4'hA; msg_valid high for 1 cycle, 1 cycle after the stop sample; busy low afterwards.
REQ-027 serial_in low for 1 clock, then high -> no msg_valid, no frame_err; received_message unchanged.
REQ-028 After a good frame of 4'h3, send a frame of 4'h5 with stop = 0 -> frame_err pulses once and received_message stays 4'h3.
REQ-029 With SIMP_COMM_PARITY_EN: 4'h7 with parity 0 -> frame_err; 4'h7 with parity 1 -> msg_valid and received_message = 4'h7.
REQ-030 rst_n pulsed low during data bit 2 -> all outputs 0 immediately; the next full frame of 4'hC is received correctly.
REQ-031 Two back-to-back frames 4'h1 then 4'hF with no idle gap -> two msg_valid pulses, with received_message = 4'h1 then 4'hF.
